// File: rtl/fir_poly_interp.sv
// rtl/fir_poly_interp.sv - polyphase interpolation FIR, L = 2^os_mode outputs per input frame
module fir_poly_interp #(
  parameter int CH        = 2,
  parameter int DW        = 32,
  parameter int CW        = 32,
  parameter int HIST_AW   = 7,
  parameter int TAPS      = 124,
  parameter int OUT_SHIFT = 31
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 enable,
  input  logic [1:0]           os_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DW-1:0]     x_in,
  output logic                 out_valid,
  output logic [CH*DW-1:0]     y_out,
  output logic [2:0]           out_phase,
  output logic                 busy,
  input  logic                 coef_we,
  input  logic [HIST_AW+2:0]   coef_addr,
  input  logic [CW-1:0]        coef_data
);

  localparam int AW  = DW + CW + HIST_AW;
  localparam int PW  = DW + CW;
  localparam int CAW = HIST_AW + 3;
  localparam int HD  = 1 << HIST_AW;

  localparam logic [HIST_AW-1:0] H_ONE    = HIST_AW'(1);
  localparam logic [HIST_AW-1:0] J_LAST   = HIST_AW'(TAPS - 1);
  localparam logic [HIST_AW-1:0] CLR_LAST = {HIST_AW{1'b1}};
  localparam logic signed [AW:0] RND      = {{AW{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [AW:0] SAT_MAX  = {{(AW + 2 - DW){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN  = {{(AW + 2 - DW){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_WAIT_IN, S_MAC, S_DRAIN, S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] hist_mem [CH][HD];
  logic [CW-1:0] coef_mem [1 << CAW];

  logic [HIST_AW-1:0] clr_q, clr_d;
  logic [HIST_AW-1:0] wp_q, wp_d;
  logic [HIST_AW-1:0] j_q, j_d;
  logic [2:0]         k_q, k_d;
  logic               drn_q, drn_d;
  logic [1:0]         os_l_q, os_l_d;
  logic               v1_q, v1_d;
  logic               v2_q, v2_d;

  logic signed [DW-1:0] hist_rd_q [CH];
  logic signed [DW-1:0] hist_rd_d [CH];
  logic signed [CW-1:0] coef_rd_q, coef_rd_d;
  logic signed [PW-1:0] prod_q [CH];
  logic signed [PW-1:0] prod_d [CH];
  logic signed [AW-1:0] acc_q [CH];
  logic signed [AW-1:0] acc_d [CH];

  logic [CH*DW-1:0] y_out_q, y_out_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       out_phase_q, out_phase_d;

  logic               accept;
  logic               hist_we;
  logic [HIST_AW-1:0] hist_wa;
  logic               coef_wr;
  logic [HIST_AW-1:0] rd_addr;
  logic [CAW-1:0]     coef_ra;
  logic [2:0]         k_last;
  logic               acc_clr;
  logic signed [AW:0] rnd_sum [CH];
  logic signed [AW:0] shifted [CH];
  logic [DW-1:0]      sat_y [CH];

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= S_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CLEAR:   if (clr_q == CLR_LAST) state_d = S_IDLE;
      S_IDLE:    if (enable) state_d = S_WAIT_IN;
      S_WAIT_IN: if (in_valid) state_d = S_MAC;
      S_MAC:     if (j_q == J_LAST) state_d = S_DRAIN;
      S_DRAIN:   if (drn_q) state_d = S_OUT;
      S_OUT:     state_d = (k_q == k_last) ? S_WAIT_IN : S_MAC;
      default:   state_d = S_CLEAR;
    endcase
    // enable drops abort everything except the history wipe
    if (!enable && state_q != S_CLEAR) state_d = S_IDLE;
  end

  always_comb begin
    in_ready    = (state_q == S_WAIT_IN) && enable;
    busy        = (state_q != S_IDLE);
    accept      = in_ready && in_valid;
    out_valid_d = (state_q == S_OUT) && enable;
    hist_we     = !preset && ((state_q == S_CLEAR) || accept);
    hist_wa     = (state_q == S_CLEAR) ? clr_q : wp_q;
    coef_wr     = !preset && coef_we && (state_q == S_IDLE);
  end

  always_comb begin
    clr_d  = (state_q == S_CLEAR) ? clr_q + H_ONE : '0;
    wp_d   = wp_q;
    if (state_q == S_CLEAR) begin
      wp_d = '0;
    end else if (accept) begin
      wp_d = wp_q + H_ONE;
    end
    j_d    = (state_q == S_MAC) ? j_q + H_ONE : '0;
    k_last = ~(3'b111 << os_l_q);
    k_d    = k_q;
    if (accept) begin
      k_d = '0;
    end else if (state_q == S_OUT && k_q != k_last) begin
      k_d = k_q + 3'd1;
    end
    drn_d  = (state_q == S_DRAIN) && !drn_q;
    os_l_d = (state_q == S_IDLE && enable) ? os_mode : os_l_q;
    v1_d   = (state_q == S_MAC) && enable;
    v2_d   = v1_q && enable;

    // newest sample sits at wp-1; tap j walks backwards through the ring
    rd_addr   = wp_q - H_ONE - j_q;
    coef_ra   = (CAW'(j_q) << os_l_q) | CAW'(k_q);
    coef_rd_d = coef_mem[coef_ra];
    acc_clr   = !enable || (state_q != S_MAC && state_q != S_DRAIN);

    y_out_d     = y_out_q;
    out_phase_d = out_valid_d ? k_q : out_phase_q;
    for (int c = 0; c < CH; c++) begin
      hist_rd_d[c] = hist_mem[c][rd_addr];
      prod_d[c]    = $signed({{CW{hist_rd_q[c][DW-1]}}, hist_rd_q[c]}) *
                     $signed({{DW{coef_rd_q[CW-1]}}, coef_rd_q});
      if (acc_clr) begin
        acc_d[c] = '0;
      end else if (v2_q) begin
        acc_d[c] = acc_q[c] + $signed({{HIST_AW{prod_q[c][PW-1]}}, prod_q[c]});
      end else begin
        acc_d[c] = acc_q[c];
      end
      rnd_sum[c] = $signed({acc_q[c][AW-1], acc_q[c]}) + RND;
      shifted[c] = rnd_sum[c] >>> OUT_SHIFT;
      if (shifted[c] > SAT_MAX) begin
        sat_y[c] = {1'b0, {(DW - 1){1'b1}}};
      end else if (shifted[c] < SAT_MIN) begin
        sat_y[c] = {1'b1, {(DW - 1){1'b0}}};
      end else begin
        sat_y[c] = shifted[c][DW-1:0];
      end
      if (out_valid_d) y_out_d[c*DW +: DW] = sat_y[c];
    end
  end

  always_ff @(posedge pclk) begin
    if (coef_wr) coef_mem[coef_addr] <= coef_data;
    if (hist_we) begin
      for (int c = 0; c < CH; c++) begin
        hist_mem[c][hist_wa] <= (state_q == S_CLEAR) ? '0 : x_in[c*DW +: DW];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      clr_q       <= '0;
      wp_q        <= '0;
      j_q         <= '0;
      k_q         <= '0;
      drn_q       <= 1'b0;
      os_l_q      <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      coef_rd_q   <= '0;
      y_out_q     <= '0;
      out_valid_q <= 1'b0;
      out_phase_q <= '0;
      for (int c = 0; c < CH; c++) begin
        hist_rd_q[c] <= '0;
        prod_q[c]    <= '0;
        acc_q[c]     <= '0;
      end
    end else begin
      clr_q       <= clr_d;
      wp_q        <= wp_d;
      j_q         <= j_d;
      k_q         <= k_d;
      drn_q       <= drn_d;
      os_l_q      <= os_l_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      coef_rd_q   <= coef_rd_d;
      y_out_q     <= y_out_d;
      out_valid_q <= out_valid_d;
      out_phase_q <= out_phase_d;
      for (int c = 0; c < CH; c++) begin
        hist_rd_q[c] <= hist_rd_d[c];
        prod_q[c]    <= prod_d[c];
        acc_q[c]     <= acc_d[c];
      end
    end
  end

  assign y_out     = y_out_q;
  assign out_valid = out_valid_q;
  assign out_phase = out_phase_q;

endmodule

// File: doc/fir_poly_interp.md
# fir_poly_interp

Parametrised polyphase interpolation FIR. It is the next generation of the stage-1 oversampling filter in the audio upsampling chain, with configurable width, tap count, channel count and ratio. Each accepted input frame produces L = 2^os_mode output frames. Additions over the previous stage:
- run-time loadable coefficients
- valid/ready input handshake
- per-output valid strobe
- rounded, saturated output
- history clear after reset

## Interface
Parameters:
- CH, 2: channel count; channels run in parallel, one multiplier each
- DW, 32: sample width, signed
- CW, 32: coefficient width, signed
- HIST_AW, 7: history depth is 2^HIST_AW samples per channel
- TAPS, 124: taps per polyphase branch; must satisfy 1 <= TAPS <= 2^HIST_AW
- OUT_SHIFT, 31: right shift applied to the accumulator at output

Ports (clock and reset first):
- pclk  in  1  sole clock
- preset  in  1  synchronous, active-high reset
- enable  in  1  low forces IDLE and aborts the current frame
- os_mode  in  2  ratio select: 0=1x, 1=2x, 2=4x, 3=8x; sampled only when leaving IDLE
- in_valid  in  1  x_in holds a valid frame
- in_ready  out  1  block accepts a frame this cycle
- x_in  in  CH*DW  channel c at [c*DW +: DW]
- out_valid  out  1  one-cycle strobe marking y_out valid
- y_out  out  CH*DW  channel packing as x_in; holds last value between strobes
- out_phase  out  3  polyphase index k of the current y_out
- busy  out  1  high in every state except IDLE
- coef_we  in  1  coefficient write strobe; honoured only in IDLE
- coef_addr  in  HIST_AW+3  prototype tap index n
- coef_data  in  CW  coefficient value h[n]

## Operation
- **Storage**
  - Coefficient RAM holds prototype h[n], n = j*L + k, with j = 0..TAPS-1 and k = 0..L-1. It is not reset.
  - Per-channel circular history RAM with write pointer wp.
- **States:** CLEAR, IDLE, WAIT_IN, MAC, DRAIN, OUT.
- **CLEAR** (entered on preset)
  - Writes 0 to every history location, 2^HIST_AW cycles; wp := 0.
  - Then goes to IDLE.
- **IDLE**
  - Coefficient writes accepted here.
  - If enable=1: latch os_mode into L, go to WAIT_IN.
- **WAIT_IN**
  - in_ready = 1.
  - On in_valid: write x_in to hist[wp], wp++, k := 0, j := 0, go to MAC.
- **MAC**
  - Lasts TAPS cycles.
  - Each cycle reads hist[wp-1-j] and coef[j*L+k]; j++.
  - The product feeds the accumulator through a 2-stage pipeline (RAM read, registered multiply).
- **DRAIN**
  - 2 cycles to flush the pipeline.
- **OUT**
  - y = sat_DW((acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT).
  - out_valid = 1, out_phase = k, accumulator cleared.
  - If k = L-1: go to WAIT_IN. Otherwise k++, j := 0, go to MAC.
- **Arithmetic**
  - Accumulator is DW+CW+HIST_AW bits signed and cannot overflow.
  - Saturation clamps to [-2^(DW-1), 2^(DW-1)-1].
- **enable low** (any state except CLEAR)
  - Next state is IDLE.
  - Partial sum discarded, no out_valid.
  - History and wp preserved.
- **Ignored inputs**
  - coef_we outside IDLE: ignored.
  - in_valid while in_ready=0: no effect; upstream holds the frame.

## Timing
- **Reset values** (next edge with preset=1):
  - in_ready=0, out_valid=0, y_out=0, out_phase=0, busy=1 (state CLEAR).
- **Input-to-output latency:** accept edge to first out_valid is TAPS+3 cycles.
- **Output spacing:** consecutive out_valid within a frame are TAPS+3 cycles apart.
- **Next frame:** in_ready rises the cycle after the last OUT of a frame.
- **Throughput budget:** TAPS=124 gives 127 cycles per output, within the 128-cycle budget at 45.1584 MHz / 352.8 kHz.
- **Coefficient writes:** a write in IDLE is visible to the first MAC after the next IDLE exit.
- **os_mode:** a change while busy takes effect only after the next IDLE.
- **Wrap-around:** wp wraps mod 2^HIST_AW; reads at wp-1-j wrap the same way.
- **preset mid-frame:** abort immediately, re-enter CLEAR. Coefficients survive.

## Test plan
Bench config unless noted: CH=2, DW=16, CW=16, HIST_AW=2, TAPS=4, OUT_SHIFT=15.
- **Impulse, 1x.**
  - Load h[0..3] = 0x4000, 0x2000, 0x1000, 0x0800.
  - Send x=0x4000 on both channels, then three zero frames.
  - -> y = 0x2000, 0x1000, 0x0800, 0x0400, each at spacing 7 cycles plus handshake.
- **Impulse, 8x.**
  - Load h[n] = n*0x100 for n = 0..31; send one impulse 0x7FFF.
  - -> eight out_valid with out_phase 0..7; phase k first output = round(0x7FFF*k*0x100 / 2^15).
  - -> over the following frames, the sequence reproduces h[n] in order.
- **Saturation and rounding.**
  - All h = 0x7FFF, x = 0x7FFF -> y = 0x7FFF.
  - All h = 0x7FFF, x = 0x8000 -> y = 0x8000.
  - h[0] = 1, others 0, x = 0x4000 -> y = 1 (round half up).
- **Handshake and abort.**
  - Hold in_valid high for 20 frames: in_ready pulses exactly once per frame, no frame lost.
  - Drop enable mid-MAC: out_valid stays 0 and busy falls next cycle.
  - Re-enable: outputs continue from the preserved history.
- **Reset and clear.**
  - Fill history with 0x1234, assert preset mid-frame.
  - -> busy high for 4 CLEAR cycles; the first frame x = 0 yields y = 0 with coefficients unchanged.
- **Ignored controls.**
  - coef_we while busy: coefficient RAM unchanged.
  - os_mode change during MAC: output count for the current frame unchanged.
